// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter: round-robin sharing of one 2-to-4 line decoder among
// four requesters. A grant is held until the owner signals done or withdraws
// its request. One break-before-make cycle (en_n=1) separates two grants.
// Optional feature macro: ARB_TIMEOUT_EN adds a hold counter that forces a
// release after MAX_HOLD grant cycles and pulses 'timeout' during that release.
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic       sel_a,
  output logic       sel_b,
  output logic       en_n,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // The hold counter must be able to reach MAX_HOLD-1.
  if (MAX_HOLD < 2 || MAX_HOLD > (2 ** HOLD_W) - 1) begin : g_bad_cfg
    $error("rr_decoder_arbiter: MAX_HOLD out of range for HOLD_W");
  end

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] sel_q, sel_d;
  logic       en_n_q, en_n_d;
  logic [3:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       timeout_d;
  logic [1:0] pick;
  logic       pick_valid;
  logic       release_req;
  logic       forced;

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q;
`endif

  // Round-robin search starting just after the last owner; nearest wins.
  always_comb begin
    logic [1:0] cand;
    pick       = 2'd0;
    pick_valid = 1'b0;
    cand       = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; outputs default to their idle values.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    sel_d       = 2'd0;
    en_n_d      = 1'b1;
    grant_d     = 4'd0;
    busy_d      = 1'b0;
    timeout_d   = 1'b0;
    release_req = done | ~req[idx_q];
    forced      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d      = hold_q;
    forced      = (hold_q == HOLD_W'(MAX_HOLD - 1)) && !release_req;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          idx_d   = pick;
          sel_d   = pick;
          en_n_d  = 1'b0;
          grant_d = 4'b0001 << pick;
          busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
`ifdef ARB_TIMEOUT_EN
        hold_d = hold_q + HOLD_W'(1);
`endif
        if (release_req || forced) begin
          state_d   = RELEASE;
          busy_d    = 1'b1;
          timeout_d = forced;
        end else begin
          sel_d   = idx_q;
          en_n_d  = 1'b0;
          grant_d = 4'b0001 << idx_q;
          busy_d  = 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        ptr_d   = idx_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any grant without a release cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd3;
      idx_q     <= 2'd0;
      sel_q     <= 2'd0;
      en_n_q    <= 1'b1;
      grant_q   <= 4'd0;
      busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      en_n_q    <= en_n_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign sel_a = sel_q[1];
  assign sel_b = sel_q[0];
  assign en_n  = en_n_q;
  assign grant = grant_q;
  assign busy  = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{timeout_d, forced};
`endif

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed testbench for rr_decoder_arbiter. Each scenario task drives inputs
// one cycle at a time and compares the registered outputs against
// hand-computed status words.
module tb_rr_decoder_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic       sel_a, sel_b, en_n, busy, timeout;
  logic [3:0] grant;

  int pass_count  = 0;
  int check_count = 0;
  bit monitor_on  = 0;

  // Full status word: {grant, sel_a, sel_b, en_n, busy, timeout}
  wire [8:0] st_full = {grant, sel_a, sel_b, en_n, busy, timeout};
  // Status word without select lines (select is only meaningful in GRANT)
  wire [6:0] st_bus  = {grant, en_n, busy, timeout};

  localparam logic [8:0] RST_F  = 9'b0000_00_1_0_0;
  localparam logic [8:0] G0     = 9'b0001_00_0_1_0;
  localparam logic [8:0] G1     = 9'b0010_01_0_1_0;
  localparam logic [8:0] G2     = 9'b0100_10_0_1_0;
  localparam logic [8:0] G3     = 9'b1000_11_0_1_0;
  localparam logic [6:0] IDLE_S = 7'b0000_1_0_0;
  localparam logic [6:0] REL_S  = 7'b0000_1_1_0;
  localparam logic [6:0] REL_TO = 7'b0000_1_1_1;

  rr_decoder_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .sel_a  (sel_a),
    .sel_b  (sel_b),
    .en_n   (en_n),
    .grant  (grant),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enable low exactly when a grant is present, and grant never has two bits set.
  always @(negedge clk) begin
    if (monitor_on) begin
      check_count++;
      if (((en_n == 1'b0) != (grant != 4'd0)) || !$onehot0(grant))
        $display("[TB] FAIL invariant got en_n=%b grant=%b required en_n==0 iff one-hot grant", en_n, grant);
      else
        pass_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'd0; done = 1'b0;
    tick(); tick();
    check_count++;
    if (st_full !== RST_F) $display("[TB] FAIL reset got %b expected %b", st_full, RST_F);
    else pass_count++;
    rst = 1'b0;
    monitor_on = 1'b1;
    tick();
    check_count++;
    if (st_bus !== IDLE_S) $display("[TB] FAIL idle_no_req got %b expected %b", st_bus, IDLE_S);
    else pass_count++;
  endtask

  task automatic test_single_grant();
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_count++;
      if (st_full !== G2) $display("[TB] FAIL single_grant_c%0d got %b expected %b", c, st_full, G2);
      else pass_count++;
    end
    done = 1'b1;
    tick();
    check_count++;
    if (st_bus !== REL_S) $display("[TB] FAIL single_release got %b expected %b", st_bus, REL_S);
    else pass_count++;
    done = 1'b0; req = 4'd0;
    tick();
    check_count++;
    if (st_bus !== IDLE_S) $display("[TB] FAIL single_idle got %b expected %b", st_bus, IDLE_S);
    else pass_count++;
    tick();
    check_count++;
    if (st_bus !== IDLE_S) $display("[TB] FAIL single_stay_idle got %b expected %b", st_bus, IDLE_S);
    else pass_count++;
  endtask

  task automatic test_round_robin();
    logic [8:0] exp_seq [5];
    exp_seq = '{G0, G1, G2, G3, G0};
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      check_count++;
      if (st_full !== exp_seq[g]) $display("[TB] FAIL rr_grant%0d got %b expected %b", g, st_full, exp_seq[g]);
      else pass_count++;
      done = 1'b1;
      if (g == 4) req = 4'd0;
      tick();
      check_count++;
      if (st_bus !== REL_S) $display("[TB] FAIL rr_release%0d got %b expected %b", g, st_bus, REL_S);
      else pass_count++;
      done = 1'b0;
      tick();
      check_count++;
      if (st_bus !== IDLE_S) $display("[TB] FAIL rr_gap%0d got %b expected %b", g, st_bus, IDLE_S);
      else pass_count++;
      if (g < 4) tick();
    end
  endtask

  task automatic test_done_and_drop();
    // Last owner was requester 0, so requester 1 is searched first.
    req = 4'b0110;
    tick();
    check_count++;
    if (st_full !== G1) $display("[TB] FAIL dd_grant1 got %b expected %b", st_full, G1);
    else pass_count++;
    done = 1'b1; req = 4'b0100;
    tick();
    check_count++;
    if (st_bus !== REL_S) $display("[TB] FAIL dd_release got %b expected %b", st_bus, REL_S);
    else pass_count++;
    done = 1'b0;
    tick();
    check_count++;
    if (st_bus !== IDLE_S) $display("[TB] FAIL dd_single_release got %b expected %b", st_bus, IDLE_S);
    else pass_count++;
    tick();
    check_count++;
    if (st_full !== G2) $display("[TB] FAIL dd_grant2 got %b expected %b", st_full, G2);
    else pass_count++;
    done = 1'b1; tick();
    done = 1'b0; req = 4'd0; tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    req = 4'b0001;
    tick();
    for (int c = 0; c < 8; c++) begin
      check_count++;
      if (st_full !== G0) $display("[TB] FAIL to_hold_c%0d got %b expected %b", c, st_full, G0);
      else pass_count++;
      tick();
    end
    check_count++;
    if (st_bus !== REL_TO) $display("[TB] FAIL to_forced_release got %b expected %b", st_bus, REL_TO);
    else pass_count++;
    tick();
    check_count++;
    if (st_bus !== IDLE_S) $display("[TB] FAIL to_idle got %b expected %b", st_bus, IDLE_S);
    else pass_count++;
    tick();
    check_count++;
    if (st_full !== G0) $display("[TB] FAIL to_regrant got %b expected %b", st_full, G0);
    else pass_count++;
    req = 4'd0;
    tick();
    check_count++;
    if (st_bus !== REL_S) $display("[TB] FAIL to_drop_release got %b expected %b", st_bus, REL_S);
    else pass_count++;
    tick();
  endtask
`else
  task automatic test_timeout();
    req = 4'b0001;
    tick();
    for (int c = 0; c < 12; c++) begin
      check_count++;
      if (st_full !== G0) $display("[TB] FAIL hold_c%0d got %b expected %b", c, st_full, G0);
      else pass_count++;
      tick();
    end
    req = 4'd0;
    tick();
    check_count++;
    if (st_bus !== REL_S) $display("[TB] FAIL hold_drop_release got %b expected %b", st_bus, REL_S);
    else pass_count++;
    tick();
    check_count++;
    if (st_bus !== IDLE_S) $display("[TB] FAIL hold_idle got %b expected %b", st_bus, IDLE_S);
    else pass_count++;
  endtask
`endif

  task automatic test_reset_mid_grant();
    req = 4'b1000;
    tick();
    check_count++;
    if (st_full !== G3) $display("[TB] FAIL rm_grant3 got %b expected %b", st_full, G3);
    else pass_count++;
    tick();
    rst = 1'b1;
    tick();
    check_count++;
    if (st_full !== RST_F) $display("[TB] FAIL rm_reset got %b expected %b", st_full, RST_F);
    else pass_count++;
    rst = 1'b0; req = 4'b1001;
    tick();
    check_count++;
    if (st_full !== G0) $display("[TB] FAIL rm_first_after_reset got %b expected %b", st_full, G0);
    else pass_count++;
    done = 1'b1; tick();
    done = 1'b0; tick();
    tick();
    check_count++;
    if (st_full !== G3) $display("[TB] FAIL rm_fair_next got %b expected %b", st_full, G3);
    else pass_count++;
    done = 1'b1; req = 4'd0; tick();
    done = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; req = 4'd0; done = 1'b0;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_done_and_drop();
    test_timeout();
    test_reset_mid_grant();
    monitor_on = 1'b0;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
